// File: rtl/perip_bridge_if.sv
// CPU data-port bundle between the single-cycle CPU (master) and perip_bridge (slave).
// perip_rdata is combinational from perip_addr.
interface perip_bridge_if;
    logic [31:0] perip_addr;
    logic        perip_wen;
    logic [31:0] perip_wdata;
    logic [31:0] perip_rdata;

    modport master (
        output perip_addr,
        output perip_wen,
        output perip_wdata,
        input  perip_rdata
    );

    modport slave (
        input  perip_addr,
        input  perip_wen,
        input  perip_wdata,
        output perip_rdata
    );
endinterface

// File: rtl/perip_bridge.sv
// perip_bridge: decodes the CPU data port into a DRAM window, GPO/GPI register banks and a down-counting timer.
// Optional feature macro PERIP_IRQ_EN: adds the irq output and makes TIMER_CTRL bit2 (IRQ_EN) writable.
module perip_bridge #(
    parameter int unsigned DRAM_AW   = 16,
    parameter int unsigned N_GPO     = 2,
    parameter int unsigned N_GPI     = 2,
    parameter int unsigned TIMER_W   = 32,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_F000
) (
    input  logic                 cpu_clk,
    input  logic                 cpu_rst,
    perip_bridge_if.slave        perip,
    output logic [DRAM_AW-1:0]   dram_addr,
    output logic                 dram_we,
    output logic [31:0]          dram_wdata,
    input  logic [31:0]          dram_rdata,
    input  logic [N_GPI*32-1:0]  gpi,
    output logic [N_GPO*32-1:0]  gpo,
    output logic                 timer_expired
`ifdef PERIP_IRQ_EN
    ,
    output logic                 irq
`endif
);

    localparam logic [3:0] REG_GPO  = 4'h0;
    localparam logic [3:0] REG_GPI  = 4'h1;
    localparam logic [3:0] REG_TMR  = 4'h2;
    localparam logic [5:0] W_CNT    = 6'd0;
    localparam logic [5:0] W_CTRL   = 6'd1;
    localparam logic [5:0] W_RELOAD = 6'd2;
    localparam logic [5:0] W_STAT   = 6'd3;

    logic       mmio_sel_s;
    logic       mmio_we_s;
    logic [3:0] region_s;
    logic [5:0] word_s;
    logic       wr_cnt_s;
    logic       wr_ctrl_s;
    logic       wr_reload_s;
    logic       wr_stat_s;
    logic       unused_s;

    assign mmio_sel_s  = (perip.perip_addr[31:12] == MMIO_BASE[31:12]);
    assign mmio_we_s   = perip.perip_wen & mmio_sel_s;
    assign region_s    = perip.perip_addr[11:8];
    assign word_s      = perip.perip_addr[7:2];
    assign wr_cnt_s    = mmio_we_s && (region_s == REG_TMR) && (word_s == W_CNT);
    assign wr_ctrl_s   = mmio_we_s && (region_s == REG_TMR) && (word_s == W_CTRL);
    assign wr_reload_s = mmio_we_s && (region_s == REG_TMR) && (word_s == W_RELOAD);
    assign wr_stat_s   = mmio_we_s && (region_s == REG_TMR) && (word_s == W_STAT);
    assign unused_s    = ^perip.perip_addr[1:0];

    assign dram_addr  = perip.perip_addr[DRAM_AW+1:2];
    assign dram_we    = perip.perip_wen & ~mmio_sel_s;
    assign dram_wdata = perip.perip_wdata;

    logic [N_GPO*32-1:0] gpo_q, gpo_d;
    logic [N_GPI*32-1:0] gpi_meta_q, gpi_sync_q;
    logic [TIMER_W-1:0]  cnt_q, cnt_d, reload_q, reload_d;
    logic                en_q, en_d, auto_q, auto_d, expired_q, expired_d, expire_s;
`ifdef PERIP_IRQ_EN
    logic                irqen_q, irqen_d, irq_q, irq_d;
`endif

    // GPO bank next state: word-indexed writes inside the first 256 bytes
    always_comb begin
        gpo_d = gpo_q;
        for (int i = 0; i < int'(N_GPO); i++) begin
            if (mmio_we_s && (region_s == REG_GPO) && (word_s == 6'(i))) begin
                gpo_d[32*i +: 32] = perip.perip_wdata;
            end else begin
                gpo_d[32*i +: 32] = gpo_q[32*i +: 32];
            end
        end
    end

    // Timer next state: hardware count first, CPU writes override, expiry beats W1C
    always_comb begin
        cnt_d     = cnt_q;
        en_d      = en_q;
        auto_d    = auto_q;
        reload_d  = reload_q;
        expired_d = expired_q;
        expire_s  = 1'b0;
        if (en_q) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - TIMER_W'(1'b1);
            end else begin
                expire_s = 1'b1;
                if (auto_q) begin
                    cnt_d = reload_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end else begin
            cnt_d = cnt_q;
        end
        if (wr_cnt_s) begin
            cnt_d = perip.perip_wdata[TIMER_W-1:0];
        end else begin
            cnt_d = cnt_d;
        end
        if (wr_ctrl_s) begin
            en_d   = perip.perip_wdata[0];
            auto_d = perip.perip_wdata[1];
        end else begin
            auto_d = auto_q;
        end
        if (wr_reload_s) begin
            reload_d = perip.perip_wdata[TIMER_W-1:0];
        end else begin
            reload_d = reload_q;
        end
        if (expire_s) begin
            expired_d = 1'b1;
        end else if (wr_stat_s && perip.perip_wdata[0]) begin
            expired_d = 1'b0;
        end else begin
            expired_d = expired_q;
        end
    end

`ifdef PERIP_IRQ_EN
    // IRQ enable bit and the registered interrupt, built from next-state values
    always_comb begin
        if (wr_ctrl_s) begin
            irqen_d = perip.perip_wdata[2];
        end else begin
            irqen_d = irqen_q;
        end
        irq_d = expired_d & irqen_d;
    end
`endif

    // State registers with synchronous reset
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            gpo_q      <= '0;
            gpi_meta_q <= '0;
            gpi_sync_q <= '0;
            cnt_q      <= '0;
            reload_q   <= '0;
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            expired_q  <= 1'b0;
`ifdef PERIP_IRQ_EN
            irqen_q    <= 1'b0;
            irq_q      <= 1'b0;
`endif
        end else begin
            gpo_q      <= gpo_d;
            gpi_meta_q <= gpi;
            gpi_sync_q <= gpi_meta_q;
            cnt_q      <= cnt_d;
            reload_q   <= reload_d;
            en_q       <= en_d;
            auto_q     <= auto_d;
            expired_q  <= expired_d;
`ifdef PERIP_IRQ_EN
            irqen_q    <= irqen_d;
            irq_q      <= irq_d;
`endif
        end
    end

    assign gpo           = gpo_q;
    assign timer_expired = expired_q;
`ifdef PERIP_IRQ_EN
    assign irq           = irq_q;
`endif

    logic [31:0] cnt_ext_s, reload_ext_s, ctrl_s, rdata_s;

    // Zero-extend the timer fields to the 32-bit bus
    always_comb begin
        cnt_ext_s                   = 32'd0;
        cnt_ext_s[TIMER_W-1:0]      = cnt_q;
        reload_ext_s                = 32'd0;
        reload_ext_s[TIMER_W-1:0]   = reload_q;
`ifdef PERIP_IRQ_EN
        ctrl_s = {29'd0, irqen_q, auto_q, en_q};
`else
        ctrl_s = {29'd0, 1'b0, auto_q, en_q};
`endif
    end

    // Zero-wait read mux; anything unmapped reads 0
    always_comb begin
        rdata_s = 32'd0;
        if (!mmio_sel_s) begin
            rdata_s = dram_rdata;
        end else begin
            case (region_s)
                REG_GPO: begin
                    for (int i = 0; i < int'(N_GPO); i++) begin
                        if (word_s == 6'(i)) begin
                            rdata_s = gpo_q[32*i +: 32];
                        end else begin
                            rdata_s = rdata_s;
                        end
                    end
                end
                REG_GPI: begin
                    for (int j = 0; j < int'(N_GPI); j++) begin
                        if (word_s == 6'(j)) begin
                            rdata_s = gpi_sync_q[32*j +: 32];
                        end else begin
                            rdata_s = rdata_s;
                        end
                    end
                end
                REG_TMR: begin
                    case (word_s)
                        W_CNT:    rdata_s = cnt_ext_s;
                        W_CTRL:   rdata_s = ctrl_s;
                        W_RELOAD: rdata_s = reload_ext_s;
                        W_STAT:   rdata_s = {31'd0, expired_q};
                        default:  rdata_s = 32'd0;
                    endcase
                end
                default: rdata_s = 32'd0;
            endcase
        end
    end

    assign perip.perip_rdata = rdata_s;

endmodule

// File: tb/tb_perip_bridge.sv
// Randomized self-checking bench for perip_bridge against a register-level behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_perip_bridge;
    localparam int NGPO = 2;
    localparam int NGPI = 2;
    localparam int AW   = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [AW-1:0]        dram_addr;
    logic                 dram_we;
    logic [31:0]          dram_wdata;
    logic [31:0]          dram_rdata;
    logic [NGPI*32-1:0]   gpi;
    logic [NGPO*32-1:0]   gpo;
    logic                 timer_expired;
`ifdef PERIP_IRQ_EN
    logic                 irq;
`endif

    always #5 clk = ~clk;

    perip_bridge_if bus ();

    perip_bridge dut (
        .cpu_clk       (clk),
        .cpu_rst       (rst),
        .perip         (bus),
        .dram_addr     (dram_addr),
        .dram_we       (dram_we),
        .dram_wdata    (dram_wdata),
        .dram_rdata    (dram_rdata),
        .gpi           (gpi),
        .gpo           (gpo),
        .timer_expired (timer_expired)
`ifdef PERIP_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    int checks = 0;
    int passed = 0;

    // Model state: what software would observe in each register
    logic [31:0]        gpo_m [NGPO];
    logic [NGPI*32-1:0] gpi_h1, gpi_h2;
    logic [31:0]        cnt_m, reload_m;
    logic               en_m, auto_m, irqen_m, exp_m;
    logic [NGPI*32-1:0] gpi_v;
    bit                 model_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    function automatic bit is_mmio(input logic [31:0] a);
        return a[31:12] == 20'hFFFFF;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        int unsigned off;
        int unsigned idx;
        if (!is_mmio(a)) return dram_rdata;
        off = int'(a[11:0]) & 32'hFFC;
        if (off < 32'h100) begin
            idx = off / 4;
            return (idx < NGPO) ? gpo_m[idx] : 32'd0;
        end
        if (off < 32'h200) begin
            idx = (off - 32'h100) / 4;
            return (idx < NGPI) ? gpi_h2[idx*32 +: 32] : 32'd0;
        end
        case (off)
            32'h200: return cnt_m;
            32'h204: return {29'd0, irqen_m, auto_m, en_m};
            32'h208: return reload_m;
            32'h20C: return {31'd0, exp_m};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic [31:0] a, input logic w,
                              input logic [31:0] d, input logic [NGPI*32-1:0] g);
        logic [31:0] ncnt;
        logic        nen, nexp, expire;
        int unsigned off;
        if (r) begin
            for (int i = 0; i < NGPO; i++) gpo_m[i] = 32'd0;
            gpi_h1 = '0; gpi_h2 = '0;
            cnt_m = 32'd0; reload_m = 32'd0;
            en_m = 1'b0; auto_m = 1'b0; irqen_m = 1'b0; exp_m = 1'b0;
            return;
        end
        gpi_h2 = gpi_h1;
        gpi_h1 = g;
        expire = 1'b0;
        ncnt = cnt_m;
        nen = en_m;
        if (en_m) begin
            if (cnt_m != 32'd0) ncnt = cnt_m - 32'd1;
            else begin
                expire = 1'b1;
                if (auto_m) ncnt = reload_m;
                else nen = 1'b0;
            end
        end
        nexp = exp_m;
        if (w && is_mmio(a)) begin
            off = int'(a[11:0]) & 32'hFFC;
            if (off < 32'h100) begin
                if (off / 4 < NGPO) gpo_m[off/4] = d;
            end else begin
                case (off)
                    32'h200: ncnt = d;
                    32'h204: begin
                        nen = d[0];
                        auto_m = d[1];
`ifdef PERIP_IRQ_EN
                        irqen_m = d[2];
`endif
                    end
                    32'h208: reload_m = d;
                    32'h20C: if (d[0]) nexp = 1'b0;
                    default: ;
                endcase
            end
        end
        if (expire) nexp = 1'b1;
        cnt_m = ncnt;
        en_m = nen;
        exp_m = nexp;
    endtask

    task automatic compare_all();
        logic [NGPO*32-1:0] gpo_exp;
        for (int i = 0; i < NGPO; i++) gpo_exp[i*32 +: 32] = gpo_m[i];
        chk("rdata", bus.perip_rdata, model_rd(bus.perip_addr));
        chk("dram_addr", dram_addr, bus.perip_addr[AW+1:2]);
        chk("dram_we", dram_we, bus.perip_wen & ~is_mmio(bus.perip_addr));
        chk("dram_wdata", dram_wdata, bus.perip_wdata);
        chk("gpo", gpo, gpo_exp);
        chk("timer_expired", timer_expired, exp_m);
`ifdef PERIP_IRQ_EN
        chk("irq", irq, exp_m & irqen_m);
`endif
    endtask

    task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic [31:0] d);
        @(negedge clk);
        rst = r;
        bus.perip_addr = a;
        bus.perip_wen = w;
        bus.perip_wdata = d;
        dram_rdata = $urandom;
        gpi = gpi_v;
        #2;
        if (model_valid) compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(rst, bus.perip_addr, bus.perip_wen, bus.perip_wdata, gpi);
        if (rst) model_valid = 1'b1;
    endtask

    task automatic op(input logic [31:0] a, input logic w, input logic [31:0] d);
        drive(1'b0, a, w, d);
        tick();
    endtask

    task automatic rd_lit(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b0, a, 1'b0, 32'd0);
        chk(name, bus.perip_rdata, exp);
        tick();
    endtask

    initial begin
        logic [31:0] a, d;
        logic        w, r;
        int          sel;

        gpi_v = '0;
        drive(1'b1, 32'd0, 1'b0, 32'd0);
        tick();

        // reset state
        drive(1'b0, 32'hFFFF_F200, 1'b0, 32'd0);
        chk("reset_gpo", gpo, 64'd0);
        chk("reset_expired", timer_expired, 1'b0);
        chk("reset_cnt", bus.perip_rdata, 32'd0);
        tick();

        // DRAM pass-through
        drive(1'b0, 32'h0000_0040, 1'b1, 32'h1234_5678);
        chk("dram_we_lit", dram_we, 1'b1);
        chk("dram_addr_lit", dram_addr, 16'h0010);
        tick();
        drive(1'b0, 32'h0000_0040, 1'b0, 32'd0);
        chk("dram_we_idle", dram_we, 1'b0);
        chk("dram_rd_lit", bus.perip_rdata, dram_rdata);
        tick();
        drive(1'b0, 32'hFFFF_F000, 1'b1, 32'h0000_0055);
        chk("dram_we_mmio", dram_we, 1'b0);
        tick();

        // GPO / GPI
        op(32'hFFFF_F004, 1'b1, 32'hA5A5_0001);
        drive(1'b0, 32'hFFFF_F004, 1'b0, 32'd0);
        chk("gpo1_lit", gpo[63:32], 32'hA5A5_0001);
        chk("gpo0_lit", gpo[31:0], 32'h0000_0055);
        tick();
        gpi_v[31:0] = 32'h0000_00FF;
        rd_lit("gpi_edge0", 32'hFFFF_F100, 32'd0);
        rd_lit("gpi_edge1", 32'hFFFF_F100, 32'd0);
        rd_lit("gpi_edge2", 32'hFFFF_F100, 32'h0000_00FF);
        rd_lit("gpi_unmapped", 32'hFFFF_F1FC, 32'd0);
        rd_lit("gpo_oob", 32'hFFFF_F008, 32'd0);

        // one-shot timer
        op(32'hFFFF_F200, 1'b1, 32'd3);
        op(32'hFFFF_F204, 1'b1, 32'h1);
        rd_lit("os_cnt3", 32'hFFFF_F200, 32'd3);
        rd_lit("os_cnt2", 32'hFFFF_F200, 32'd2);
        rd_lit("os_cnt1", 32'hFFFF_F200, 32'd1);
        rd_lit("os_stat0", 32'hFFFF_F20C, 32'd0);
        rd_lit("os_stat1", 32'hFFFF_F20C, 32'd1);
        rd_lit("os_ctrl", 32'hFFFF_F204, 32'd0);
        rd_lit("os_cnt0", 32'hFFFF_F200, 32'd0);
        op(32'hFFFF_F20C, 1'b1, 32'd1);

        // auto-reload with W1C collisions
        op(32'hFFFF_F208, 1'b1, 32'd4);
        op(32'hFFFF_F200, 1'b1, 32'd4);
        op(32'hFFFF_F204, 1'b1, 32'h3);
        rd_lit("ar_stat_pre", 32'hFFFF_F20C, 32'd0);
        repeat (3) op(32'hFFFF_F200, 1'b0, 32'd0);
        op(32'hFFFF_F20C, 1'b1, 32'd1);
        rd_lit("ar_w1c_collide", 32'hFFFF_F20C, 32'd1);
        op(32'hFFFF_F20C, 1'b1, 32'd1);
        rd_lit("ar_w1c_clear", 32'hFFFF_F20C, 32'd0);
        rd_lit("ar_cnt", 32'hFFFF_F200, 32'd1);
        op(32'hFFFF_F204, 1'b1, 32'h0);

        // reset mid-count
        op(32'hFFFF_F200, 1'b1, 32'd7);
        op(32'hFFFF_F204, 1'b1, 32'h1);
        drive(1'b1, 32'hFFFF_F200, 1'b0, 32'd0);
        tick();
        drive(1'b0, 32'hFFFF_F200, 1'b0, 32'd0);
        chk("rst_cnt", bus.perip_rdata, 32'd0);
        chk("rst_gpo", gpo, 64'd0);
        chk("rst_expired", timer_expired, 1'b0);
        tick();
        repeat (10) op(32'hFFFF_F204, 1'b0, 32'd0);
        rd_lit("rst_no_expiry", 32'hFFFF_F20C, 32'd0);

`ifdef PERIP_IRQ_EN
        op(32'hFFFF_F200, 1'b1, 32'd0);
        op(32'hFFFF_F204, 1'b1, 32'h5);
        drive(1'b0, 32'hFFFF_F204, 1'b0, 32'd0);
        chk("irq_pre", irq, 1'b0);
        tick();
        drive(1'b0, 32'hFFFF_F204, 1'b0, 32'd0);
        chk("irq_set", irq, 1'b1);
        tick();
        op(32'hFFFF_F20C, 1'b1, 32'd1);
        drive(1'b0, 32'hFFFF_F204, 1'b0, 32'd0);
        chk("irq_clr", irq, 1'b0);
        chk("irqen_rd", bus.perip_rdata, 32'h4);
        tick();
`else
        op(32'hFFFF_F204, 1'b1, 32'h4);
        rd_lit("irqen_ignored", 32'hFFFF_F204, 32'd0);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            d = $urandom;
            case (sel)
                0, 1: a = $urandom & 32'h7FFF_FFFF;
                2: a = 32'hFFFF_F000 + ($urandom_range(0, 7) << 2);
                3: a = 32'hFFFF_F100 + ($urandom_range(0, 3) << 2);
                4, 5, 6, 7: begin
                    a = 32'hFFFF_F200 + ($urandom_range(0, 3) << 2);
                    if (a[3:2] == 2'd0 || a[3:2] == 2'd2) d = $urandom_range(0, 12);
                end
                8: a = 32'hFFFF_F000 + ($urandom_range(32'h84, 32'h3FF) << 2);
                default: a = 32'hFFFF_F1FC;
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) gpi_v = {$urandom, $urandom};
            drive(r, a, w, d);
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/perip_bridge.md
Name: perip_bridge

Overview:
- Sits between the CPU data port (perip_*) and the SoC's data-side targets.
- Replaces the direct CPU-to-DRAM hookup with an address-decoded bridge with three target groups:
  - DRAM window.
  - Parametrised banks of output and input registers (LEDs, switches).
  - A programmable down-counting timer.
- Read data is a combinational mux of registered or DRAM state, so the single-cycle CPU keeps its zero-wait data path.

Parameters:
- DRAM_AW, 16, DRAM word-address width; dram_addr = perip_addr[DRAM_AW+1:2].
- N_GPO, 2, number of 32-bit output registers (1..8).
- N_GPI, 2, number of 32-bit input ports (1..8).
- TIMER_W, 32, timer counter and reload width (8..32); wider write bits are dropped, reads are zero-extended.
- MMIO_BASE, 32'hFFFF_F000, base of the 4 KiB MMIO page.

Ports:
- cpu_clk  in  1  sole clock.
- cpu_rst  in  1  synchronous, active-high reset.
- perip_addr  in  32  CPU byte address.
- perip_wen  in  1  CPU write strobe, single cycle.
- perip_wdata  in  32  CPU write data.
- perip_rdata  out  32  read data, combinational from perip_addr.
- dram_addr  out  DRAM_AW  DRAM word address.
- dram_we  out  1  DRAM write enable.
- dram_wdata  out  32  DRAM write data (= perip_wdata).
- dram_rdata  in  32  DRAM async read data.
- gpi  in  N_GPI*32  raw external inputs; port j = bits [32j+31:32j].
- gpo  out  N_GPO*32  output registers, packed as for gpi.
- timer_expired  out  1  sticky expiry flag.

Behaviour:
- Decode
  - perip_addr[31:12] == MMIO_BASE[31:12] selects MMIO; anything else selects DRAM.
  - dram_we = perip_wen & ~mmio_sel.
- MMIO offsets (perip_addr[11:0], word-aligned; bits [1:0] are ignored):
  - 0x000+4i: GPO[i], read/write.
  - 0x100+4j: GPI[j], read-only.
  - 0x200: TIMER_CNT, read/write.
  - 0x204: TIMER_CTRL. bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN (see Optional Feature); other bits read 0.
  - 0x208: TIMER_RELOAD, read/write.
  - 0x20C: TIMER_STAT. bit0 EXPIRED; writing 1 to bit0 clears it.
  - Unmapped offsets and i >= N_GPO, j >= N_GPI: reads return 0, writes are ignored.
- Writes take effect at the rising cpu_clk edge where perip_wen = 1. A read in the following cycle returns the new value.
- GPI: two-flop synchroniser per bit, so a gpi change is visible on reads 2 cycles later.
- Reset (cpu_rst = 1 at the edge):
  - All GPO, TIMER_CNT, TIMER_CTRL, TIMER_RELOAD, EXPIRED and the synchroniser flops go to 0.
  - The gpo and timer_expired outputs read 0 from the first cycle after reset.
  - Reset mid-count aborts the count; no expiry is generated.
- Timer, evaluated per edge with EN = 1:
  - CNT != 0: CNT <= CNT-1.
  - CNT == 0: EXPIRED <= 1. If AUTORELOAD, CNT <= RELOAD and EN stays 1; otherwise CNT stays 0 and EN <= 0.
  - Period with AUTORELOAD is RELOAD+1 cycles.
  - RELOAD = 0 with AUTORELOAD: EXPIRED is set every cycle.
- Simultaneous events:
  - A CPU write to TIMER_CNT overrides the decrement or reload in that cycle.
  - A CPU write to TIMER_CTRL overrides the hardware EN clear.
  - A hardware expiry set overrides a W1C clear in the same cycle, so EXPIRED stays 1.
- timer_expired = EXPIRED register; no combinational path from inputs.

Optional Feature:
- Macro: PERIP_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit) = EXPIRED & IRQ_EN, registered-sourced, reset 0.
  - TIMER_CTRL bit2 is read/write.
- Undefined:
  - No irq port.
  - TIMER_CTRL bit2 writes are ignored and it reads 0.

Test Plan:
- DRAM pass-through: write 0x1234_5678 to 0x0000_0040 -> dram_we = 1 for one cycle, dram_addr = 0x10; a read of 0x40 returns dram_rdata. Write to 0xFFFF_F000 -> dram_we = 0.
- GPO/GPI: write 0xA5A5_0001 to 0xFFFF_F004 -> gpo[63:32] = 0xA5A5_0001 next cycle. Drive gpi[31:0] = 0xFF -> a read of 0xFFFF_F100 returns 0xFF from the 2nd edge on. A read of 0xFFFF_F1FC returns 0.
- One-shot timer: CNT = 3, CTRL = 0x1 -> CNT steps 2, 1, 0; EXPIRED = 1 on the 4th edge after the CTRL write; EN reads 0; CNT holds 0.
- Auto-reload: RELOAD = 4, CNT = 4, CTRL = 0x3 -> EXPIRED set every 5 cycles. A W1C to 0x20C on the same edge as expiry leaves EXPIRED = 1; a W1C on a non-expiry edge clears it.
- Reset mid-operation: cpu_rst = 1 for 1 cycle while CNT = 7 and EN = 1 -> all registers, gpo and timer_expired are 0 next cycle; no later expiry.
- With PERIP_IRQ_EN: CTRL = 0x5, CNT = 0 -> irq = 1 after the next edge; a W1C on 0x20C drops irq to 0 the following cycle.
